// File: rtl/fx_mult_arbiter.sv
// Two-requester round-robin front end sharing one Q6.10 signed multiplier.
// Each requester has a private accumulator; results return tagged, two cycles after acceptance.
module fx_mult_arbiter #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic              i_req0_acc,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  input  logic              i_req1_acc,
  output logic              o_valid,
  output logic              o_id,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sat
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int RND_W  = PROD_W - FRAC_W;

  // Returns {sat, value}: round-half-to-even on the dropped fraction, then clamp to DATA_W.
  function automatic logic [DATA_W:0] round_sat(input logic signed [PROD_W-1:0] p);
    logic                    g, r, s;
    logic signed [RND_W-1:0] rounded;
    logic [RND_W-DATA_W:0]   top;
    g       = p[FRAC_W];
    r       = p[FRAC_W-1];
    s       = |p[FRAC_W-2:0];
    rounded = $signed(p[PROD_W-1:FRAC_W]) + $signed({{(RND_W-1){1'b0}}, ((r & s) | (g & r))});
    top     = rounded[RND_W-1:DATA_W-1];
    if ((&top) || !(|top))
      round_sat = {1'b0, rounded[DATA_W-1:0]};
    else if (rounded[RND_W-1])
      round_sat = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else
      round_sat = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  function automatic logic [DATA_W:0] add_sat(input logic signed [DATA_W-1:0] x,
                                               input logic signed [DATA_W-1:0] y);
    logic signed [DATA_W:0] sum;
    sum = {x[DATA_W-1], x} + {y[DATA_W-1], y};
    if (sum[DATA_W] == sum[DATA_W-1])
      add_sat = {1'b0, sum[DATA_W-1:0]};
    else if (sum[DATA_W])
      add_sat = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else
      add_sat = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // Stage p0: arbitration, operand select, multiply and round
  logic                     r_last_id;
  logic                     w_gnt0_p0, w_gnt1_p0, w_xfer_p0, w_acc_p0;
  logic signed [DATA_W-1:0] w_a_p0, w_b_p0;
  logic signed [PROD_W-1:0] w_prod_p0;
  logic        [DATA_W:0]   w_rs_p0;

  // r_last_id==1 means requester 0 wins the next tie
  assign w_gnt0_p0 = i_req0_valid & (~i_req1_valid | r_last_id);
  assign w_gnt1_p0 = i_req1_valid & (~i_req0_valid | ~r_last_id);
  assign w_xfer_p0 = w_gnt0_p0 | w_gnt1_p0;
  assign o_req0_ready = w_gnt0_p0;
  assign o_req1_ready = w_gnt1_p0;

  assign w_a_p0    = w_gnt1_p0 ? $signed(i_req1_a) : $signed(i_req0_a);
  assign w_b_p0    = w_gnt1_p0 ? $signed(i_req1_b) : $signed(i_req0_b);
  assign w_acc_p0  = w_gnt1_p0 ? i_req1_acc : i_req0_acc;
  assign w_prod_p0 = w_a_p0 * w_b_p0;
  assign w_rs_p0   = round_sat(w_prod_p0);

  always_ff @(posedge i_clk) begin
    if (i_rst)          r_last_id <= 1'b1;
    else if (w_xfer_p0) r_last_id <= w_gnt1_p0;
  end

  // Stage p1: registered rounded product with its tag
  logic                     r_vld_p1, r_id_p1, r_acc_p1, r_sat_p1;
  logic signed [DATA_W-1:0] r_prod_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= w_xfer_p0;
  end

  always_ff @(posedge i_clk) begin
    r_id_p1   <= w_gnt1_p0;
    r_acc_p1  <= w_acc_p0;
    r_sat_p1  <= w_rs_p0[DATA_W];
    r_prod_p1 <= $signed(w_rs_p0[DATA_W-1:0]);
  end

  // Stage p2: accumulate, update accumulator, drive outputs
  logic signed [DATA_W-1:0] r_accum [2];
  logic        [DATA_W:0]   w_sum_p2;
  logic signed [DATA_W-1:0] w_res_p2;
  logic                     w_sat_p2;
  logic                     r_vld_p2, r_id_p2, r_sat_p2;
  logic        [DATA_W-1:0] r_data_p2;

  assign w_sum_p2 = add_sat(r_accum[r_id_p1], r_prod_p1);
  assign w_res_p2 = r_acc_p1 ? $signed(w_sum_p2[DATA_W-1:0]) : r_prod_p1;
  assign w_sat_p2 = r_sat_p1 | (r_acc_p1 & w_sum_p2[DATA_W]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_accum[0] <= '0;
      r_accum[1] <= '0;
    end else if (r_vld_p1) begin
      r_accum[r_id_p1] <= w_res_p2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p2  <= 1'b0;
      r_id_p2   <= 1'b0;
      r_sat_p2  <= 1'b0;
      r_data_p2 <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_id_p2   <= r_id_p1;
        r_sat_p2  <= w_sat_p2;
        r_data_p2 <= w_res_p2;
      end
    end
  end

  assign o_valid = r_vld_p2;
  assign o_id    = r_id_p2;
  assign o_data  = r_data_p2;
  assign o_sat   = r_sat_p2;

endmodule

// File: tb/tb_fx_mult_arbiter.sv
// Directed bench for fx_mult_arbiter: reset, arbitration, rounding, saturation, accumulate, mid-run reset.
module tb_fx_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_acc;
  logic        req1_valid, req1_ready, req1_acc;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        out_valid, out_id, out_sat;
  logic [15:0] out_data;

  int n_checks = 0;
  int n_errs   = 0;

  logic        s_id   [32];
  logic [15:0] s_a    [32];
  logic [15:0] s_b    [32];
  logic        s_acc  [32];
  logic [15:0] s_exp  [32];
  logic        s_sat  [32];
  int          s_n = 0;

  always #5 clk = ~clk;

  fx_mult_arbiter #(.DATA_W(16), .FRAC_W(10)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_acc(req0_acc),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_acc(req1_acc),
    .o_valid(out_valid), .o_id(out_id), .o_data(out_data), .o_sat(out_sat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic push(input logic id, input logic [15:0] a, input logic [15:0] b,
                      input logic acc, input logic [15:0] exp, input logic sat);
    s_id[s_n] = id; s_a[s_n] = a; s_b[s_n] = b; s_acc[s_n] = acc;
    s_exp[s_n] = exp; s_sat[s_n] = sat;
    s_n++;
  endtask

  // Issues queued ops on consecutive cycles and checks each result two cycles later.
  task automatic run_stream(input string name);
    for (int t = 0; t < s_n + 2; t++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (t < s_n) begin
        if (s_id[t]) begin
          req1_valid = 1'b1; req1_a = s_a[t]; req1_b = s_b[t]; req1_acc = s_acc[t];
        end else begin
          req0_valid = 1'b1; req0_a = s_a[t]; req0_b = s_b[t]; req0_acc = s_acc[t];
        end
      end
      #1;
      if (t < s_n)
        chk($sformatf("%s[%0d].ready", name, t), {31'd0, s_id[t] ? req1_ready : req0_ready}, 32'd1);
      if (t >= 2) begin
        chk($sformatf("%s[%0d].valid", name, t-2), {31'd0, out_valid}, 32'd1);
        chk($sformatf("%s[%0d].id",    name, t-2), {31'd0, out_id},    {31'd0, s_id[t-2]});
        chk($sformatf("%s[%0d].data",  name, t-2), {16'd0, out_data},  {16'd0, s_exp[t-2]});
        chk($sformatf("%s[%0d].sat",   name, t-2), {31'd0, out_sat},   {31'd0, s_sat[t-2]});
      end
    end
    @(posedge clk); #2;
    chk($sformatf("%s.idle_valid", name), {31'd0, out_valid}, 32'd0);
    s_n = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_rdy [5];
    logic [15:0] exp_dat [5];
    rst = 1'b1;
    idle_inputs();
    req0_a = '0; req0_b = '0; req0_acc = 1'b0;
    req1_a = '0; req1_b = '0; req1_acc = 1'b0;

    // Reset state; a transfer during reset must be discarded
    repeat (3) @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_a = 16'h0400; req0_b = 16'h0400;
    #1;
    chk("rst.ready0", {31'd0, req0_ready}, 32'd1);
    chk("rst.ready1", {31'd0, req1_ready}, 32'd0);
    chk("rst.valid",  {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; idle_inputs();
    #1;
    chk("rst.id",   {31'd0, out_id},   32'd0);
    chk("rst.data", {16'd0, out_data}, 32'd0);
    chk("rst.sat",  {31'd0, out_sat},  32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      chk($sformatf("rst.drop%0d", k), {31'd0, out_valid}, 32'd0);
    end

    // Arbitration: both valid 4 cycles, then a lone req1
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
    exp_dat = '{16'h0400, 16'h0800, 16'h0400, 16'h0800, 16'h0800};
    for (int t = 0; t < 7; t++) begin
      @(posedge clk); #1;
      req0_valid = (t < 4);
      req1_valid = (t < 5);
      req0_a = 16'h0400; req0_b = 16'h0400; req0_acc = 1'b0;
      req1_a = 16'h0800; req1_b = 16'h0400; req1_acc = 1'b0;
      #1;
      if (t < 5)
        chk($sformatf("arb[%0d].ready", t), {30'd0, req1_ready, req0_ready}, {30'd0, exp_rdy[t]});
      if (t >= 2) begin
        chk($sformatf("arb[%0d].valid", t-2), {31'd0, out_valid}, 32'd1);
        chk($sformatf("arb[%0d].id", t-2), {31'd0, out_id}, {31'd0, exp_rdy[t-2][1]});
        chk($sformatf("arb[%0d].data", t-2), {16'd0, out_data}, {16'd0, exp_dat[t-2]});
      end
    end
    idle_inputs();

    // Multiply, rounding and multiply saturation
    push(1'b0, 16'h0600, 16'h0800, 1'b0, 16'h0C00, 1'b0);
    push(1'b0, 16'h0001, 16'h0200, 1'b0, 16'h0000, 1'b0);
    push(1'b1, 16'h0001, 16'h0600, 1'b0, 16'h0002, 1'b0);
    push(1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1);
    push(1'b1, 16'h8000, 16'h7FFF, 1'b0, 16'h8000, 1'b1);
    push(1'b0, 16'hFC00, 16'h0C00, 1'b0, 16'hF400, 1'b0);
    run_stream("mul");

    // Back-to-back accumulates with interleaved ids
    push(1'b0, 16'h0400, 16'h0400, 1'b0, 16'h0400, 1'b0);
    push(1'b0, 16'h0400, 16'h0800, 1'b1, 16'h0C00, 1'b0);
    push(1'b1, 16'h0400, 16'h0400, 1'b0, 16'h0400, 1'b0);
    push(1'b0, 16'h0400, 16'h0400, 1'b1, 16'h1000, 1'b0);
    push(1'b1, 16'h0400, 16'h0400, 1'b1, 16'h0800, 1'b0);
    push(1'b0, 16'h7000, 16'h0400, 1'b0, 16'h7000, 1'b0);
    push(1'b0, 16'h2000, 16'h0400, 1'b1, 16'h7FFF, 1'b1);
    push(1'b1, 16'h9000, 16'h0400, 1'b0, 16'h9000, 1'b0);
    push(1'b1, 16'hE000, 16'h0400, 1'b1, 16'h8000, 1'b1);
    run_stream("acc");

    // Reset with an operation in flight
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 16'h0600; req1_b = 16'h0800; req1_acc = 1'b0;
    #1;
    chk("mid.ready1", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    idle_inputs(); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid.valid2", {31'd0, out_valid}, 32'd0);
    chk("mid.data",   {16'd0, out_data},  32'd0);
    chk("mid.id",     {31'd0, out_id},    32'd0);
    chk("mid.sat",    {31'd0, out_sat},   32'd0);
    @(posedge clk); #2;
    chk("mid.valid3", {31'd0, out_valid}, 32'd0);
    push(1'b0, 16'h0400, 16'h0400, 1'b1, 16'h0400, 1'b0);
    push(1'b1, 16'h0800, 16'h0400, 1'b1, 16'h0800, 1'b0);
    run_stream("post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
